mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, meaning data/address width.
REQ-002 SHALL have parameter REG_COUNT, default 32, meaning register-file entries; REG_BITS = $clog2(REG_COUNT).
REQ-003 SHALL have parameter CTRL_SIZE, default 21, meaning full decode control width; this stage receives CTRL_SIZE-7 (14) bits.
REQ-004 SHALL have clk  input  1  the single clock; all state on its rising edge.
REQ-005 SHALL have rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have exc_mem_reg  input  REG_BITS+1+CTRL_SIZE-7+3*REG_WIDTH  packed {rd, write_en, ctrl[13:0], alu_out, store_data, return_pc}.
REQ-007 SHALL have in_valid  input  1  exc_mem_reg holds a live instruction.
REQ-008 SHALL have in_ready  output  1  stage accepts exc_mem_reg this cycle; low stalls upstream.
REQ-009 SHALL have the data-bus ports dmem_req (out, 1), dmem_we (out, 1), dmem_addr (out, REG_WIDTH), dmem_wdata (out, REG_WIDTH), dmem_be (out, 4), dmem_gnt (in, 1), dmem_rvalid (in, 1) and dmem_rdata (in, REG_WIDTH).
REQ-010 SHALL have wb_valid, wb_en, wb_rd (out, 1/1/REG_BITS) and wb_data (out, REG_WIDTH), forming the registered mem-to-writeback interface.

Function
REQ-011 ctrl[13]=mem_read, ctrl[12]=mem_write, ctrl[11:10]=size (00 byte, 01 half, 10 word, 11 treated as word), ctrl[9]=load_unsigned, ctrl[8:7]=wb_sel (00 alu_out, 01 load data, 10 return_pc, 11 alu_out); ctrl[6:0] SHALL be ignored.
REQ-012 FSM states: IDLE, REQ, WAIT; in_ready SHALL be 1 only in IDLE.
REQ-013 IDLE with in_valid and no memory op: SHALL register wb_valid=1, wb_rd=rd, wb_en=write_en, wb_data per wb_sel the next edge (1-cycle latency); FSM stays in IDLE.
REQ-014 IDLE with in_valid and a memory op: SHALL capture the fields, go to REQ, and drive dmem_req=1 from the next cycle, registered with addr/we/be/wdata.
REQ-015 REQ: dmem_req/addr/we/be/wdata SHALL hold stable until dmem_gnt; on gnt, a store SHALL go to IDLE and write wb_valid=1, wb_en=0, and a load SHALL go to WAIT with dmem_req=0.
REQ-016 WAIT: on dmem_rvalid the stage SHALL write wb_valid=1, wb_en=write_en and wb_data=extracted load, then go to IDLE; dmem_rvalid outside WAIT SHALL be ignored.
REQ-017 mem_read and mem_write both set: SHALL execute as a store.
REQ-018 dmem_addr SHALL be alu_out with bits[1:0] cleared.
REQ-019 Store lanes: the byte SHALL be replicated 4x with be=0001<<addr[1:0]; the half SHALL be replicated 2x with be=0011<<{addr[1],0}; a word SHALL use be=1111.
REQ-020 Load extract: SHALL shift dmem_rdata right by 8*addr[1:0] (half uses addr[1]), then zero-extend if load_unsigned, else sign-extend.
REQ-021 wb_valid SHALL be a 1-cycle pulse per retired instruction and SHALL otherwise be 0.

Reset
REQ-022 rstn low SHALL asynchronously force FSM=IDLE and dmem_req, dmem_we, dmem_be, wb_valid, wb_en, wb_rd, wb_data, dmem_addr and dmem_wdata to 0; mid-transaction reset SHALL abandon the access, and a later gnt or rvalid SHALL be ignored.

Configuration
REQ-023 With MEM_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL issue no dmem_req, SHALL retire next cycle with wb_en=0, and SHALL pulse output misalign_err (1 bit) for one cycle.
REQ-024 Without MEM_MISALIGN_TRAP_EN, the misalign_err port SHALL not exist and misaligned accesses SHALL proceed with low bits handled per REQ-018 to REQ-020.

Structure
REQ-025 A shared package SHALL hold the size encodings, wb_sel encodings, the ctrl bit-index constants and the FSM state enum.
REQ-026 Sub-module mem_align SHALL be combinational and SHALL generate the store be/wdata and perform load extraction and extension.

Verification
REQ-027 ALU op: alu_out=0x1234, wb_sel=00, write_en=1, rd=5 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, in_ready stays 1.
REQ-028 sb with addr=0x103 and data=0xAB, gnt after 2 wait cycles -> dmem_addr=0x100, be=1000, wdata=0xABABABAB held for 3 cycles, then wb_valid=1 and wb_en=0.
REQ-029 lb with addr=0x102 and rdata=0x00800000 -> wb_data=0xFFFFFF80; the same load with load_unsigned=1 -> 0x00000080.
REQ-030 lw with gnt, then rstn pulsed low in WAIT, then rvalid -> dmem_req=0 immediately, no wb_valid, and in_ready=1 after reset.
REQ-031 MEM_MISALIGN_TRAP_EN defined, lw with addr=0x102 -> no dmem_req, misalign_err=1 for 1 cycle, wb_valid=1, wb_en=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: ctrl bit positions, access sizes,
// writeback selects, FSM states and the misalignment predicate.
package mem_stage_pkg;

    localparam int CTRL_MEM_READ  = 13;
    localparam int CTRL_MEM_WRITE = 12;
    localparam int CTRL_SIZE_HI   = 11;
    localparam int CTRL_SIZE_LO   = 10;
    localparam int CTRL_UNSIGNED  = 9;
    localparam int CTRL_WB_SEL_HI = 8;
    localparam int CTRL_WB_SEL_LO = 7;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        WB_ALU     = 2'b00,
        WB_LOAD    = 2'b01,
        WB_PC      = 2'b10,
        WB_ALU_ALT = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } state_e;

    // Any size encoding with bit 1 set is a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SIZE_HALF) && addr_lo[0]) || (size[1] && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_align: purely combinational lane logic -- store byte enables / replicated
// write data, and load extraction with zero or sign extension.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic [1:0]           size,
    input  logic [1:0]           addr_lo,
    input  logic                 load_unsigned,
    input  logic [REG_WIDTH-1:0] store_data,
    input  logic [REG_WIDTH-1:0] rdata,
    output logic [3:0]           be,
    output logic [REG_WIDTH-1:0] wdata,
    output logic [REG_WIDTH-1:0] load_data
);

    logic [REG_WIDTH-1:0] shifted;

    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        shifted   = rdata;
        load_data = shifted;
        case (size)
            SIZE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {(REG_WIDTH/8){store_data[7:0]}};
                shifted   = rdata >> {addr_lo, 3'b000};
                load_data = load_unsigned ? {{(REG_WIDTH-8){1'b0}}, shifted[7:0]}
                                          : {{(REG_WIDTH-8){shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                // Halves only look at addr[1]; addr[0] is dropped.
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata     = {(REG_WIDTH/16){store_data[15:0]}};
                shifted   = rdata >> {addr_lo[1], 4'b0000};
                load_data = load_unsigned ? {{(REG_WIDTH-16){1'b0}}, shifted[15:0]}
                                          : {{(REG_WIDTH-16){shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: turns EX/MEM bundles into data-bus requests and registered writeback results.
// Build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses retire without a bus request.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter  int REG_WIDTH = 32,
    parameter  int REG_COUNT = 32,
    parameter  int CTRL_SIZE = 21,
    localparam int REG_BITS  = $clog2(REG_COUNT),
    localparam int CW        = CTRL_SIZE - 7
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [REG_BITS+CW+3*REG_WIDTH:0] exc_mem_reg,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          dmem_req,
    output logic                          dmem_we,
    output logic [REG_WIDTH-1:0]          dmem_addr,
    output logic [REG_WIDTH-1:0]          dmem_wdata,
    output logic [3:0]                    dmem_be,
    input  logic                          dmem_gnt,
    input  logic                          dmem_rvalid,
    input  logic [REG_WIDTH-1:0]          dmem_rdata,
    output logic                          wb_valid,
    output logic                          wb_en,
    output logic [REG_BITS-1:0]           wb_rd,
    output logic [REG_WIDTH-1:0]          wb_data,
    output logic [1:0]                    dbg_state_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                          misalign_err
`endif
);

    // Upstream transfer happens on a rising edge where in_valid && in_ready; in_ready
    // is high only in IDLE. The bus request is held until the edge with dmem_req && dmem_gnt.
    logic [REG_BITS-1:0]  in_rd;
    logic                 in_we;
    logic [CW-1:0]        in_ctrl;
    logic [REG_WIDTH-1:0] in_alu, in_sd, in_pc;
    assign {in_rd, in_we, in_ctrl, in_alu, in_sd, in_pc} = exc_mem_reg;

    logic       in_store, in_mem, in_uns;
    logic [1:0] in_size, in_wb_sel;
    logic       unused_ctrl;
    assign in_store    = in_ctrl[CTRL_MEM_WRITE];
    assign in_mem      = in_ctrl[CTRL_MEM_READ] | in_store;
    assign in_size     = in_ctrl[CTRL_SIZE_HI:CTRL_SIZE_LO];
    assign in_uns      = in_ctrl[CTRL_UNSIGNED];
    assign in_wb_sel   = in_ctrl[CTRL_WB_SEL_HI:CTRL_WB_SEL_LO];
    assign unused_ctrl = ^in_ctrl[6:0];

    state_e               state_q;
    logic                 req_q, we_q, wb_valid_q, wb_en_q;
    logic [3:0]           be_q;
    logic [REG_WIDTH-1:0] addr_q, wdata_q, wb_data_q;
    logic [REG_BITS-1:0]  wb_rd_q, rd_q;
    logic                 rd_we_q, store_q, uns_q;
    logic [1:0]           size_q, addr_lo_q;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                 misalign_q;
    assign misalign_err = misalign_q;
`endif

    // Non-memory ops have no load data, so a load select falls back to alu_out.
    logic [REG_WIDTH-1:0] alu_wb_d;
    always_comb begin
        alu_wb_d = in_alu;
        if (in_wb_sel == WB_PC) alu_wb_d = in_pc;
    end

    logic                 idle;
    logic [3:0]           al_be;
    logic [REG_WIDTH-1:0] al_wdata, al_load;
    assign idle = (state_q == ST_IDLE);

    mem_align #(.REG_WIDTH(REG_WIDTH)) u_align (
        .size          (idle ? in_size : size_q),
        .addr_lo       (idle ? in_alu[1:0] : addr_lo_q),
        .load_unsigned (idle ? in_uns : uns_q),
        .store_data    (in_sd),
        .rdata         (dmem_rdata),
        .be            (al_be),
        .wdata         (al_wdata),
        .load_data     (al_load)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            rd_q       <= '0;
            rd_we_q    <= 1'b0;
            store_q    <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            addr_lo_q  <= 2'b00;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            wb_valid_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (!in_mem) begin
                            wb_valid_q <= 1'b1;
                            wb_en_q    <= in_we;
                            wb_rd_q    <= in_rd;
                            wb_data_q  <= alu_wb_d;
                        end
`ifdef MEM_MISALIGN_TRAP_EN
                        else if (is_misaligned(in_size, in_alu[1:0])) begin
                            wb_valid_q <= 1'b1;
                            wb_en_q    <= 1'b0;
                            wb_rd_q    <= in_rd;
                            misalign_q <= 1'b1;
                        end
`endif
                        else begin
                            rd_q      <= in_rd;
                            rd_we_q   <= in_we;
                            store_q   <= in_store;
                            uns_q     <= in_uns;
                            size_q    <= in_size;
                            addr_lo_q <= in_alu[1:0];
                            req_q     <= 1'b1;
                            we_q      <= in_store;
                            addr_q    <= {in_alu[REG_WIDTH-1:2], 2'b00};
                            be_q      <= al_be;
                            wdata_q   <= al_wdata;
                            state_q   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (store_q) begin
                            wb_valid_q <= 1'b1;
                            wb_en_q    <= 1'b0;
                            wb_rd_q    <= rd_q;
                            state_q    <= ST_IDLE;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid) begin
                        wb_valid_q <= 1'b1;
                        wb_en_q    <= rd_we_q;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= al_load;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = idle;
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign dmem_be     = be_q;
    assign wb_valid    = wb_valid_q;
    assign wb_en       = wb_en_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: fixed vectors, randomized accesses against an arithmetic
// reference model, a writeback scoreboard, and reset / misalignment sequences.
module tb_mem_stage;

    logic         clk;
    logic         rstn;
    logic [115:0] exc_mem_reg;
    logic         in_valid;
    logic         in_ready;
    logic         dmem_req, dmem_we;
    logic [31:0]  dmem_addr, dmem_wdata;
    logic [3:0]   dmem_be;
    logic         dmem_gnt, dmem_rvalid;
    logic [31:0]  dmem_rdata;
    logic         wb_valid, wb_en;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;
    logic [1:0]   dbg_state;
`ifdef MEM_MISALIGN_TRAP_EN
    logic         misalign_err;
`endif

    mem_stage dut (
        .clk         (clk),
        .rstn        (rstn),
        .exc_mem_reg (exc_mem_reg),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .wb_valid    (wb_valid),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .dbg_state_o (dbg_state)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic        mrd;
        logic        mwr;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  wbsel;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] pc;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: expected wb_data plus {check_data_and_rd, wb_en, wb_rd} per retirement.
    logic [31:0] exp_q[$];
    logic [6:0]  meta_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [31:0] d;
        logic [6:0]  m;
        if (rstn && wb_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wb_unexpected: wb_valid=1 wb_data=%h required no retirement (t=%0t)", wb_data, $time);
            end else begin
                d = exp_q.pop_front();
                m = meta_q.pop_front();
                check("wb_en", {31'd0, wb_en}, {31'd0, m[5]});
                if (m[6]) begin
                    check("wb_data", wb_data, d);
                    check("wb_rd", {27'd0, wb_rd}, {27'd0, m[4:0]});
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int unsigned a;
        int unsigned k;
        r = v;
        a = v.alu;
        r.exp_addr  = a - (a % 4);
        r.exp_be    = 4'd0;
        r.exp_wdata = 32'd0;
        r.exp_wb    = 32'd0;
        if (v.mwr) begin
            if (v.size == 2'd0) begin
                r.exp_be    = 4'(1 << (a % 4));
                r.exp_wdata = (v.sd % 256) * 32'h01010101;
            end else if (v.size == 2'd1) begin
                r.exp_be    = 4'(3 << (2 * ((a / 2) % 2)));
                r.exp_wdata = (v.sd % 65536) * 32'h00010001;
            end else begin
                r.exp_be    = 4'hF;
                r.exp_wdata = v.sd;
            end
        end else if (v.mrd) begin
            if (v.size == 2'd0) begin
                k = (v.rdata >> (8 * (a % 4))) % 256;
                if (!v.uns && k >= 128) k = k + 32'hFFFFFF00;
            end else if (v.size == 2'd1) begin
                k = (v.rdata >> (16 * ((a / 2) % 2))) % 65536;
                if (!v.uns && k >= 32768) k = k + 32'hFFFF0000;
            end else begin
                k = v.rdata;
            end
            r.exp_wb = k;
        end else begin
            r.exp_wb = (v.wbsel == 2'd2) ? v.pc : v.alu;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [4:0] rd, input logic we, input logic mrd, input logic mwr,
                                input logic [1:0] size, input logic uns, input logic [1:0] wbsel,
                                input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc,
                                input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                                input logic [31:0] exp_addr, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
        vec_t v;
        v.rd = rd; v.we = we; v.mrd = mrd; v.mwr = mwr; v.size = size; v.uns = uns;
        v.wbsel = wbsel; v.alu = alu; v.sd = sd; v.pc = pc; v.rdata = rdata;
        v.gnt_dly = gnt_dly; v.rv_dly = rv_dly; v.exp_addr = exp_addr; v.exp_be = exp_be;
        v.exp_wdata = exp_wdata; v.exp_wb = exp_wb;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input vec_t v);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        exc_mem_reg = {v.rd, v.we, v.mrd, v.mwr, v.size, v.uns, v.wbsel, 7'($urandom), v.alu, v.sd, v.pc};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exc_mem_reg = {$urandom, $urandom, $urandom, 20'($urandom)};
    endtask

    task automatic exec(input vec_t v);
        exp_q.push_back(v.exp_wb);
        meta_q.push_back({~v.mwr, v.mwr ? 1'b0 : v.we, v.rd});
        drive(v);
        if (!(v.mrd || v.mwr)) begin
            check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
            check("alu_in_ready", {31'd0, in_ready}, 32'd1);
            check("alu_no_req", {31'd0, dmem_req}, 32'd0);
        end else begin
            for (int i = 0; i <= v.gnt_dly; i++) begin
                check("req_held", {31'd0, dmem_req}, 32'd1);
                check("req_addr", dmem_addr, v.exp_addr);
                check("req_we", {31'd0, dmem_we}, {31'd0, v.mwr});
                check("req_busy", {31'd0, in_ready}, 32'd0);
                if (v.mwr) begin
                    check("req_be", {28'd0, dmem_be}, {28'd0, v.exp_be});
                    check("req_wdata", dmem_wdata, v.exp_wdata);
                end
                if (i == v.gnt_dly) begin
                    dmem_gnt = 1'b1;
                end else begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = $urandom;
                end
                @(posedge clk); #1;
                dmem_gnt    = 1'b0;
                dmem_rvalid = 1'b0;
            end
            check("req_dropped", {31'd0, dmem_req}, 32'd0);
            if (!v.mwr) begin
                check("wait_busy", {31'd0, in_ready}, 32'd0);
                repeat (v.rv_dly) begin
                    @(posedge clk); #1;
                end
                dmem_rdata  = v.rdata;
                dmem_rvalid = 1'b1;
                @(posedge clk); #1;
                dmem_rvalid = 1'b0;
                dmem_rdata  = $urandom;
            end
            check("retire_ready", {31'd0, in_ready}, 32'd1);
        end
    endtask

    // ---------------- test ----------------
    vec_t tbl[14];
    vec_t v;

    initial begin
        rstn = 1'b0; in_valid = 1'b0; exc_mem_reg = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        tbl[0]  = mk(5,  1, 0, 0, 0, 0, 0, 32'h1234,     0,            0,        0,            0, 0, 0,        4'b0000, 0,            32'h1234);
        tbl[1]  = mk(1,  1, 0, 0, 0, 0, 2, 32'h5555,     0,            32'h400,  0,            0, 0, 0,        4'b0000, 0,            32'h400);
        tbl[2]  = mk(31, 1, 0, 0, 2, 1, 3, 32'hDEADBEEF, 1,            8,        0,            0, 0, 0,        4'b0000, 0,            32'hDEADBEEF);
        tbl[3]  = mk(7,  1, 0, 1, 0, 0, 0, 32'h103,      32'hAB,       0,        0,            2, 0, 32'h100,  4'b1000, 32'hABABABAB, 0);
        tbl[4]  = mk(8,  0, 0, 1, 1, 0, 0, 32'h206,      32'h1234CAFE, 0,        0,            1, 0, 32'h204,  4'b1100, 32'hCAFECAFE, 0);
        tbl[5]  = mk(9,  1, 0, 1, 2, 0, 0, 32'h300,      32'h11223344, 0,        0,            0, 0, 32'h300,  4'b1111, 32'h11223344, 0);
        tbl[6]  = mk(10, 1, 1, 0, 0, 0, 1, 32'h102,      0,            0,        32'h00800000, 1, 2, 32'h100,  4'b0000, 0,            32'hFFFFFF80);
        tbl[7]  = mk(11, 1, 1, 0, 0, 1, 1, 32'h102,      0,            0,        32'h00800000, 0, 0, 32'h100,  4'b0000, 0,            32'h00000080);
        tbl[8]  = mk(12, 1, 1, 0, 1, 0, 0, 32'h2,        0,            0,        32'h80017FFF, 3, 1, 32'h0,    4'b0000, 0,            32'hFFFF8001);
        tbl[9]  = mk(13, 1, 1, 0, 1, 1, 0, 32'h0,        0,            0,        32'h80017FFF, 0, 1, 32'h0,    4'b0000, 0,            32'h00007FFF);
        tbl[10] = mk(14, 1, 1, 0, 2, 0, 0, 32'h40,       0,            0,        32'hCAFEF00D, 1, 0, 32'h40,   4'b0000, 0,            32'hCAFEF00D);
        tbl[11] = mk(15, 0, 1, 0, 0, 0, 0, 32'h101,      0,            0,        32'h12345678, 0, 3, 32'h100,  4'b0000, 0,            32'h00000056);
        tbl[12] = mk(16, 1, 1, 1, 0, 0, 0, 32'h1,        32'h7F,       0,        0,            1, 0, 32'h0,    4'b0010, 32'h7F7F7F7F, 0);
        tbl[13] = mk(17, 1, 1, 0, 3, 0, 0, 32'h2C,       0,            0,        32'h89ABCDEF, 0, 0, 32'h2C,   4'b0000, 0,            32'h89ABCDEF);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_we", {31'd0, dmem_we}, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) exec(tbl[i]);

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            v.rd = 5'($urandom); v.we = 1'($urandom); v.size = 2'($urandom_range(0, 3));
            v.uns = 1'($urandom); v.wbsel = 2'($urandom_range(0, 3));
            v.alu = $urandom; v.sd = $urandom; v.pc = $urandom; v.rdata = $urandom;
            v.gnt_dly = $urandom_range(0, 3); v.rv_dly = $urandom_range(0, 3);
            v.mwr = (kind == 2);
            v.mrd = (kind == 1) || (kind == 2 && $urandom_range(0, 3) == 0);
            if (kind == 0 && v.wbsel == 2'd1) v.wbsel = 2'd2;
`ifdef MEM_MISALIGN_TRAP_EN
            if (v.size == 2'd1) v.alu[0] = 1'b0;
            if (v.size[1]) v.alu[1:0] = 2'b00;
`endif
            exec(model(v));
        end

        // Reset while waiting for read data: the late rvalid and gnt must not retire anything.
        v = model(mk(20, 1, 1, 0, 2, 0, 0, 32'h80, 0, 0, 32'h5A5A5A5A, 0, 0, 0, 0, 0, 0));
        drive(v);
        check("mid_req", {31'd0, dmem_req}, 32'd1);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        check("mid_wait_req", {31'd0, dmem_req}, 32'd0);
        check("mid_wait_busy", {31'd0, in_ready}, 32'd0);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, dmem_req}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_addr", dmem_addr, 32'd0);
        check("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        dmem_rdata = 32'h5A5A5A5A;
        dmem_rvalid = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        check("late_rvalid_wb", {31'd0, wb_valid}, 32'd0);
        check("late_rvalid_ready", {31'd0, in_ready}, 32'd1);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        check("late_gnt_req", {31'd0, dmem_req}, 32'd0);
        check("late_gnt_wb", {31'd0, wb_valid}, 32'd0);
        exec(model(mk(3, 1, 0, 0, 0, 0, 0, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0)));

`ifdef MEM_MISALIGN_TRAP_EN
        v = mk(21, 1, 1, 0, 2, 0, 0, 32'h102, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'd0);
        meta_q.push_back({1'b0, 1'b0, 5'd21});
        drive(v);
        check("mis_no_req", {31'd0, dmem_req}, 32'd0);
        check("mis_err", {31'd0, misalign_err}, 32'd1);
        check("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("mis_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("mis_err_pulse", {31'd0, misalign_err}, 32'd0);
        check("mis_still_no_req", {31'd0, dmem_req}, 32'd0);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
